// File: rtl/snes_gamepad_reader_if.sv
// Bundle of the gamepad reader's control, pad link and report signals.
// The reader itself connects through the master modport; whatever drives
// en and the pad line and consumes the report uses the slave modport.
interface snes_gamepad_reader_if;
  logic       en;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [3:0] joystick;
  logic [7:0] buttons;
  logic       pad_present;
  logic       valid;
  logic       changed;

  modport master (
    input  en,
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output joystick,
    output buttons,
    output pad_present,
    output valid,
    output changed
  );

  modport slave (
    output en,
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  joystick,
    input  buttons,
    input  pad_present,
    input  valid,
    input  changed
  );
endinterface

// File: rtl/snes_gamepad_reader.sv
// SNES gamepad poller: periodically latches the pad, clocks out its 16-bit
// serial report, and publishes active-high joystick/button levels together
// with pad presence and per-scan valid/changed strobes.
module snes_gamepad_reader #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833334
) (
  input  logic                  clk,
  input  logic                  rst,
  snes_gamepad_reader_if.master bus
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int CW = $clog2(2 * HALF_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   poll_q;
  logic            tick;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      n_q, n_d;
  logic [15:0]     sr_q, sr_d;
  logic            sync1_q, sync2_q;
  logic            pad_latch_q, pad_clk_q;
  logic [3:0]      joy_q, joy_d;
  logic [7:0]      btn_q, btn_d;
  logic            present_q, present_d;
  logic            valid_q, valid_d;
  logic            changed_q, changed_d;

  // Decoded report from a complete shift register, used at the end of a scan.
  logic            new_present;
  logic [3:0]      new_joy;
  logic [7:0]      new_btn;
  logic [3:0]      n_next;

  assign tick        = (poll_q == POLL_LAST);
  assign new_present = (sr_q[15:12] == 4'b0000);
  // A missing pad reads all-pressed through the pull-down; suppress it.
  assign new_joy     = new_present ? {sr_q[5], sr_q[4], sr_q[7], sr_q[6]} : 4'h0;
  assign new_btn     = new_present ? {sr_q[9], sr_q[1], sr_q[8], sr_q[0],
                                      sr_q[11], sr_q[10], sr_q[3], sr_q[2]} : 8'h00;
  assign n_next      = n_q + 4'd1;

  // Two-flop synchroniser for the asynchronous pad data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pad_data;
      sync2_q <= sync1_q;
    end
  end

  // Free-running poll counter; wraps on every tick regardless of scan state.
  always_ff @(posedge clk) begin
    if (rst)       poll_q <= '0;
    else if (tick) poll_q <= '0;
    else           poll_q <= poll_q + PW'(1);
  end

  // State, shift register and published report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= 4'd0;
      sr_q        <= 16'h0000;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      joy_q       <= 4'h0;
      btn_q       <= 8'h00;
      present_q   <= 1'b0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      sr_q        <= sr_d;
      // Pad strobes are derived from the next state so they change exactly on
      // state-entry edges and come straight from flops.
      pad_latch_q <= (state_d == S_LATCH);
      pad_clk_q   <= (state_d != S_LOW);
      joy_q       <= joy_d;
      btn_q       <= btn_d;
      present_q   <= present_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
    end
  end

  // Next-state logic: phase timing, bit capture on pad_clk falling edges,
  // and report publication on entry to DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    n_d       = n_q;
    sr_d      = sr_q;
    joy_d     = joy_q;
    btn_d     = btn_q;
    present_d = present_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tick && bus.en) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d  = S_LOW;
          cnt_d    = '0;
          n_d      = 4'd0;
          sr_d[0]  = ~sync2_q;
        end
      end
      S_LOW: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (n_q == 4'd15) begin
            state_d   = S_DONE;
            joy_d     = new_joy;
            btn_d     = new_btn;
            present_d = new_present;
            valid_d   = 1'b1;
            changed_d = ({new_present, new_joy, new_btn} != {present_q, joy_q, btn_q});
          end else begin
            state_d      = S_LOW;
            n_d          = n_next;
            sr_d[n_next] = ~sync2_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pad_latch   = pad_latch_q;
  assign bus.pad_clk     = pad_clk_q;
  assign bus.joystick    = joy_q;
  assign bus.buttons     = btn_q;
  assign bus.pad_present = present_q;
  assign bus.valid       = valid_q;
  assign bus.changed     = changed_q;

endmodule

// File: tb/tb_snes_gamepad_reader.sv
// Directed bench for snes_gamepad_reader with a behavioural SNES pad model.
module tb_snes_gamepad_reader;
  localparam int HC = 4;
  localparam int PC = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  snes_gamepad_reader_if pad_if ();

  snes_gamepad_reader #(.HALF_CYCLES(HC), .POLL_CYCLES(PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pad_if)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset release (edge 1 = first free edge).
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Pad model: bit 0 presented while latched, advance on pad_clk rising edge.
  // pressed[i] = 1 drives raw 0 on serial bit i; ID bits are driven high.
  logic [11:0] pressed   = 12'h000;
  bit          connected = 1'b1;
  int          idx = 0;
  logic        pclk_prev = 1'b1;
  logic [15:0] raw;

  always @(negedge clk) begin
    if (pad_if.pad_latch) idx = 0;
    else if (pad_if.pad_clk && !pclk_prev) idx = idx + 1;
    pclk_prev = pad_if.pad_clk;
  end

  assign raw = {4'hF, ~pressed};
  assign pad_if.pad_data = (connected && idx < 16) ? raw[idx[3:0]] : 1'b0;

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pad_if.valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_latch(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pad_if.en = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({pad_if.pad_latch, pad_if.pad_clk, pad_if.pad_present, pad_if.valid, pad_if.changed} !== 5'b01000) begin
      nfail++;
      $display("FAIL reset_ctrl: latch/clk/present/valid/changed=%b required 01000",
               {pad_if.pad_latch, pad_if.pad_clk, pad_if.pad_present, pad_if.valid, pad_if.changed});
    end
    ncmp++;
    if ({pad_if.joystick, pad_if.buttons} !== 12'h000) begin
      nfail++;
      $display("FAIL reset_report: joy/btn=%h required 000", {pad_if.joystick, pad_if.buttons});
    end
    rst = 1'b0;
    $display("reset: checked reset values, released at negedge");
  endtask

  task automatic test_first_scan();
    int at, hi, pulses, badw, lowrun, vat;
    wait_latch(400, at);
    ncmp++;
    if (at !== 200) begin
      nfail++;
      $display("FAIL first_latch_cycle: got %0d required 200", at);
    end
    hi = 1;
    while (hi < 50) begin
      @(negedge clk);
      if (!pad_if.pad_latch) break;
      hi++;
    end
    ncmp++;
    if (hi !== 2 * HC) begin
      nfail++;
      $display("FAIL latch_width: got %0d required %0d", hi, 2 * HC);
    end
    pulses = 0; badw = 0; lowrun = 0; vat = -1;
    for (int i = 0; i < 300; i++) begin
      if (pad_if.valid) begin
        vat = cyc;
        break;
      end
      if (!pad_if.pad_clk) lowrun++;
      else if (lowrun != 0) begin
        pulses++;
        if (lowrun != HC) badw++;
        lowrun = 0;
      end
      @(negedge clk);
    end
    ncmp++;
    if (pulses !== 16 || badw !== 0) begin
      nfail++;
      $display("FAIL clk_pulses: got %0d pulses (%0d bad width) required 16 of width %0d", pulses, badw, HC);
    end
    ncmp++;
    if (vat !== 336) begin
      nfail++;
      $display("FAIL first_valid_cycle: got %0d required 336", vat);
    end
    ncmp++;
    if ({pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed} !== {1'b1, 4'h0, 8'h00, 1'b1}) begin
      nfail++;
      $display("FAIL idle_pad_report: present=%b joy=%h btn=%h changed=%b required 1 0 00 1",
               pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed);
    end
    @(negedge clk);
    ncmp++;
    if (pad_if.valid !== 1'b0) begin
      nfail++;
      $display("FAIL valid_one_cycle: valid=%b one cycle later required 0", pad_if.valid);
    end
    $display("first_scan: latch at %0d, %0d clk pulses, valid at %0d", at, pulses, vat);
  endtask

  task automatic test_buttons();
    int vat;
    pressed = 12'h000;
    pressed[0] = 1'b1;   // B
    pressed[4] = 1'b1;   // UP
    pressed[11] = 1'b1;  // TR
    wait_valid(400, vat);
    ncmp++;
    if (vat !== 536 || pad_if.buttons !== 8'h18 || pad_if.joystick !== 4'h4 || pad_if.changed !== 1'b1) begin
      nfail++;
      $display("FAIL b_up_tr: at=%0d btn=%h joy=%h changed=%b required 536 18 4 1",
               vat, pad_if.buttons, pad_if.joystick, pad_if.changed);
    end
    wait_valid(400, vat);
    ncmp++;
    if (vat !== 736 || pad_if.buttons !== 8'h18 || pad_if.changed !== 1'b0) begin
      nfail++;
      $display("FAIL b_up_tr_repeat: at=%0d btn=%h changed=%b required 736 18 0",
               vat, pad_if.buttons, pad_if.changed);
    end
    $display("buttons: B+UP+TR report btn=%h joy=%h", pad_if.buttons, pad_if.joystick);
  endtask

  task automatic test_disconnect();
    int vat;
    connected = 1'b0;
    wait_valid(400, vat);
    ncmp++;
    if (vat !== 936 || {pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed} !== {1'b0, 4'h0, 8'h00, 1'b1}) begin
      nfail++;
      $display("FAIL disconnect: at=%0d present=%b joy=%h btn=%h changed=%b required 936 0 0 00 1",
               vat, pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed);
    end
    $display("disconnect: present=%b", pad_if.pad_present);
  endtask

  task automatic test_all_pressed();
    int v1, v2;
    connected = 1'b1;
    pressed = 12'hFFF;
    wait_valid(400, v1);
    ncmp++;
    if (v1 !== 1136 || {pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed} !== {1'b1, 4'hF, 8'hFF, 1'b1}) begin
      nfail++;
      $display("FAIL all_pressed: at=%0d present=%b joy=%h btn=%h changed=%b required 1136 1 F FF 1",
               v1, pad_if.pad_present, pad_if.joystick, pad_if.buttons, pad_if.changed);
    end
    wait_valid(400, v2);
    ncmp++;
    if (v2 - v1 !== PC || pad_if.changed !== 1'b0) begin
      nfail++;
      $display("FAIL scan_period: got %0d changed=%b required %0d 0", v2 - v1, pad_if.changed, PC);
    end
    $display("all_pressed: valid at %0d and %0d", v1, v2);
  endtask

  task automatic test_reset_mid_scan();
    int at, found, vcount, vat;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (idx == 7 && !pad_if.pad_clk && !pad_if.pad_latch) begin
        found = 1;
        break;
      end
    end
    ncmp++;
    if (found !== 1) begin
      nfail++;
      $display("FAIL find_bit7_low: not reached within budget");
    end
    rst = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({pad_if.pad_clk, pad_if.pad_latch, pad_if.valid, pad_if.pad_present, pad_if.joystick, pad_if.buttons} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00}) begin
      nfail++;
      $display("FAIL mid_reset: clk=%b latch=%b valid=%b present=%b joy=%h btn=%h required 1 0 0 0 0 00",
               pad_if.pad_clk, pad_if.pad_latch, pad_if.valid, pad_if.pad_present, pad_if.joystick, pad_if.buttons);
    end
    @(negedge clk);
    rst = 1'b0;
    vcount = 0; at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pad_if.valid) vcount++;
      if (pad_if.pad_latch) begin
        at = cyc;
        break;
      end
    end
    ncmp++;
    if (at !== 200 || vcount !== 0) begin
      nfail++;
      $display("FAIL restart_latch: at=%0d stray_valids=%0d required 200 0", at, vcount);
    end
    wait_valid(400, vat);
    ncmp++;
    if (vat !== 336 || {pad_if.joystick, pad_if.buttons, pad_if.changed} !== {4'hF, 8'hFF, 1'b1}) begin
      nfail++;
      $display("FAIL restart_scan: at=%0d joy=%h btn=%h changed=%b required 336 F FF 1",
               vat, pad_if.joystick, pad_if.buttons, pad_if.changed);
    end
    $display("reset_mid_scan: restart latch at %0d, valid at %0d", at, vat);
  endtask

  task automatic test_enable();
    int at, vat, lat, c;
    wait_latch(400, at);
    repeat (20) @(negedge clk);
    pad_if.en = 1'b0;
    wait_valid(400, vat);
    ncmp++;
    if (vat !== at + 136 || pad_if.buttons !== 8'hFF) begin
      nfail++;
      $display("FAIL en_off_completes: at=%0d btn=%h required %0d FF", vat, pad_if.buttons, at + 136);
    end
    lat = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch) lat++;
    end
    ncmp++;
    if (lat !== 0) begin
      nfail++;
      $display("FAIL en_off_no_scan: %0d latch cycles required 0", lat);
    end
    c = cyc;
    pad_if.en = 1'b1;
    wait_latch(400, at);
    ncmp++;
    if (at !== (c / PC + 1) * PC) begin
      nfail++;
      $display("FAIL en_resume: latch at %0d required %0d", at, (c / PC + 1) * PC);
    end
    $display("enable: resumed with latch at %0d", at);
  endtask

  initial begin
    pad_if.en = 1'b1;
    test_reset();
    test_first_scan();
    test_buttons();
    test_disconnect();
    test_all_pressed();
    test_reset_mid_scan();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
